// File: rtl/bcdu_seq_controller.sv
// BCDU instruction sequencer: decodes 16-bit instructions into regfile/ALU/shifter/flag controls.
// Define BCDU_CTRL_SKID_EN to add a 1-entry instruction buffer usable while a repeat runs.
module bcdu_seq_controller #(
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned NUM_REGS        = 4,
  parameter int unsigned ADDR_WIDTH      = 2,
  parameter int unsigned SHIFT_AMT_WIDTH = 3,
  localparam int unsigned BCDU_OP_CODE_WIDTH    = 4,
  localparam int unsigned BCD_ALU_OP_CODE_WIDTH = 2,
  localparam int unsigned BCDU_NUM_FLAGS        = 5
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [15:0]                      i_instr,
  input  logic [3:0]                       i_digit,
  output logic                             o_wr_en,
  output logic [ADDR_WIDTH-1:0]            o_wr_addr,
  output logic [ADDR_WIDTH-1:0]            o_rd_addr_a,
  output logic [ADDR_WIDTH-1:0]            o_rd_addr_b,
  output logic                             o_ncp_en,
  output logic [BCD_ALU_OP_CODE_WIDTH-1:0] o_alu_op_code,
  output logic [SHIFT_AMT_WIDTH-1:0]       o_shl_amt,
  output logic [SHIFT_AMT_WIDTH-1:0]       o_shr_amt,
  output logic [3:0]                       o_shl_digit,
  output logic [3:0]                       o_shr_digit,
  output logic                             o_add_cin,
  output logic [BCDU_NUM_FLAGS-1:0]        o_flags_mask,
  output logic                             o_flags_save,
  output logic                             o_done,
  output logic                             o_illegal
);

  localparam int unsigned OPW  = BCDU_OP_CODE_WIDTH;
  localparam int unsigned ALUW = BCD_ALU_OP_CODE_WIDTH;
  localparam int unsigned NF   = BCDU_NUM_FLAGS;
  localparam int unsigned SAW  = SHIFT_AMT_WIDTH;
  localparam int unsigned AW   = ADDR_WIDTH;
  localparam int unsigned CNTW = 4;

  localparam logic [OPW-1:0] OP_SHL = OPW'(0);
  localparam logic [OPW-1:0] OP_SHR = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3);
  localparam logic [OPW-1:0] OP_CMP = OPW'(4);
  localparam logic [OPW-1:0] OP_CLR = OPW'(5);
  localparam logic [OPW-1:0] OP_MOV = OPW'(6);
  localparam logic [OPW-1:0] OP_ACA = OPW'(7);
  localparam logic [OPW-1:0] OP_ACS = OPW'(8);

  localparam logic [ALUW-1:0] ALU_ADD = ALUW'(0);
  localparam logic [ALUW-1:0] ALU_SHL = ALUW'(1);
  localparam logic [ALUW-1:0] ALU_SHR = ALUW'(2);
  localparam logic [ALUW-1:0] ALU_CMP = ALUW'(3);

  localparam logic [NF-1:0] FLAG_ZF = NF'(1);
  localparam logic [NF-1:0] FLAG_CF = NF'(2);
  localparam logic [NF-1:0] FLAG_GF = NF'(4);
  localparam logic [NF-1:0] FLAG_EF = NF'(8);
  localparam logic [NF-1:0] FLAG_TF = NF'(16);

  localparam logic [SAW-1:0] AMT_ND  = SAW'(NUM_DIGITS);
  localparam logic [SAW-1:0] AMT_ND1 = SAW'(NUM_DIGITS - 1);
  localparam logic [SAW-1:0] AMT_ONE = SAW'(1);

  if (AW < $clog2(NUM_REGS) || AW > 4) begin : g_bad_addr_width
    $error("bcdu_seq_controller: ADDR_WIDTH does not fit NUM_REGS");
  end

  typedef enum logic {IDLE = 1'b0, REPEAT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic            wr_en_q, wr_en_d, ncp_q, ncp_d, cin_q, cin_d;
  logic            save_q, save_d, done_q, done_d, illegal_q, illegal_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d, rd_a_q, rd_a_d, rd_b_q, rd_b_d, rd_a_c, rd_b_c;
  logic [ALUW-1:0] alu_q, alu_d;
  logic [SAW-1:0]  shl_amt_q, shl_amt_d, shr_amt_q, shr_amt_d;
  logic [3:0]      shl_digit_q, shl_digit_d, shr_digit_q, shr_digit_d;
  logic [NF-1:0]   mask_q, mask_d;

  logic            issue;
  logic [15:0]     cur_instr;
  logic [3:0]      cur_digit;

  // Instruction source: direct from the port, or from the skid buffer when it holds one
`ifdef BCDU_CTRL_SKID_EN
  logic        buf_full_q;
  logic [15:0] buf_instr_q;
  logic [3:0]  buf_digit_q;

  assign o_ready   = !buf_full_q;
  assign issue     = (state_q == IDLE) && (buf_full_q || i_valid);
  assign cur_instr = buf_full_q ? buf_instr_q : i_instr;
  assign cur_digit = buf_full_q ? buf_digit_q : i_digit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_full_q  <= 1'b0;
      buf_instr_q <= '0;
      buf_digit_q <= '0;
    end else if (state_q == IDLE) begin
      buf_full_q  <= 1'b0;
    end else if (i_valid && !buf_full_q) begin
      buf_full_q  <= 1'b1;
      buf_instr_q <= i_instr;
      buf_digit_q <= i_digit;
    end
  end
`else
  assign o_ready   = (state_q == IDLE);
  assign issue     = (state_q == IDLE) && i_valid;
  assign cur_instr = i_instr;
  assign cur_digit = i_digit;
`endif

  logic [OPW-1:0] op;
  logic [AW-1:0]  a0, a1, a2;
  logic [3:0]     lo, rep_n, shl_in;
  logic [SAW-1:0] amt_sat, fwd_amt, inv_amt;
  logic           unused_instr_bits;

  assign op      = cur_instr[15 -: OPW];
  assign a0      = cur_instr[8 +: AW];
  assign a1      = cur_instr[4 +: AW];
  assign a2      = cur_instr[0 +: AW];
  assign lo      = cur_instr[3:0];
  assign amt_sat = (cur_instr[0 +: SAW] > AMT_ND) ? AMT_ND : cur_instr[0 +: SAW];
  assign fwd_amt = cur_instr[6] ? AMT_ONE : amt_sat;
  assign inv_amt = cur_instr[6] ? AMT_ND1 : AMT_ND - amt_sat;
  assign shl_in  = (lo > 4'd9) ? cur_digit : lo;
  assign rep_n   = (lo >= 4'd1 && lo <= 4'd9) ? lo :
                   (cur_digit >= 4'd1 && cur_digit <= 4'd9) ? cur_digit : 4'd0;
  assign unused_instr_bits = ^cur_instr;

  assign o_rd_addr_a = rd_a_c;
  assign o_rd_addr_b = rd_b_c;

  // Next-state and registered-control decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_en_d     = 1'b0;
    save_d      = 1'b0;
    done_d      = 1'b0;
    illegal_d   = 1'b0;
    mask_d      = '0;
    wr_addr_d   = wr_addr_q;
    alu_d       = alu_q;
    ncp_d       = ncp_q;
    cin_d       = cin_q;
    shl_amt_d   = shl_amt_q;
    shr_amt_d   = shr_amt_q;
    shl_digit_d = shl_digit_q;
    shr_digit_d = shr_digit_q;
    rd_a_c      = rd_a_q;
    rd_b_c      = rd_b_q;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          wr_addr_d   = a0;
          rd_a_c      = a0;
          rd_b_c      = a1;
          alu_d       = ALU_CMP;
          ncp_d       = 1'b0;
          cin_d       = 1'b0;
          shl_amt_d   = '0;
          shr_amt_d   = '0;
          shl_digit_d = '0;
          shr_digit_d = '0;
          done_d      = 1'b1;
          case (op)
            OP_SHL: begin
              wr_en_d     = cur_instr[7];
              mask_d      = FLAG_ZF | FLAG_TF;
              alu_d       = ALU_SHL;
              shl_amt_d   = fwd_amt;
              shr_amt_d   = inv_amt;
              shl_digit_d = cur_instr[6] ? shl_in : 4'd0;
            end
            OP_SHR: begin
              wr_en_d     = cur_instr[7];
              mask_d      = FLAG_ZF | FLAG_TF;
              alu_d       = ALU_SHR;
              shr_amt_d   = fwd_amt;
              shl_amt_d   = inv_amt;
              shr_digit_d = cur_instr[6] ? lo : 4'd0;
            end
            OP_ADD, OP_SUB: begin
              rd_a_c  = a1;
              rd_b_c  = a2;
              wr_en_d = 1'b1;
              alu_d   = ALU_ADD;
              ncp_d   = (op == OP_SUB);
              cin_d   = (op == OP_SUB);
              mask_d  = FLAG_ZF | FLAG_CF;
            end
            OP_CMP: mask_d = FLAG_GF | FLAG_EF;
            OP_CLR: wr_en_d = 1'b1;
            OP_MOV: begin
              rd_a_c  = a1;
              wr_en_d = 1'b1;
              alu_d   = ALU_SHL;
            end
            OP_ACA, OP_ACS: begin
              alu_d = ALU_ADD;
              ncp_d = (op == OP_ACS);
              cin_d = (op == OP_ACS);
              if (rep_n != 4'd0) begin
                wr_en_d = 1'b1;
                mask_d  = FLAG_ZF | FLAG_CF;
              end
              // N >= 2: first write now, remaining N-1 writes come from REPEAT
              if (rep_n >= 4'd2) begin
                done_d  = 1'b0;
                state_d = REPEAT;
                cnt_d   = CNTW'(rep_n - 4'd2);
              end
            end
            default: illegal_d = 1'b1;
          endcase
        end
      end
      REPEAT: begin
        wr_en_d = 1'b1;
        save_d  = 1'b1;
        mask_d  = mask_q;
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    rd_a_d = rd_a_c;
    rd_b_d = rd_b_c;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      rd_a_q      <= '0;
      rd_b_q      <= '0;
      ncp_q       <= 1'b0;
      alu_q       <= ALU_CMP;
      shl_amt_q   <= '0;
      shr_amt_q   <= '0;
      shl_digit_q <= '0;
      shr_digit_q <= '0;
      cin_q       <= 1'b0;
      mask_q      <= '0;
      save_q      <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
      ncp_q       <= ncp_d;
      alu_q       <= alu_d;
      shl_amt_q   <= shl_amt_d;
      shr_amt_q   <= shr_amt_d;
      shl_digit_q <= shl_digit_d;
      shr_digit_q <= shr_digit_d;
      cin_q       <= cin_d;
      mask_q      <= mask_d;
      save_q      <= save_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
    end
  end

  assign o_wr_en       = wr_en_q;
  assign o_wr_addr     = wr_addr_q;
  assign o_ncp_en      = ncp_q;
  assign o_alu_op_code = alu_q;
  assign o_shl_amt     = shl_amt_q;
  assign o_shr_amt     = shr_amt_q;
  assign o_shl_digit   = shl_digit_q;
  assign o_shr_digit   = shr_digit_q;
  assign o_add_cin     = cin_q;
  assign o_flags_mask  = mask_q;
  assign o_flags_save  = save_q;
  assign o_done        = done_q;
  assign o_illegal     = illegal_q;

endmodule

// File: tb/tb_bcdu_seq_controller.sv
// Directed bench for bcdu_seq_controller: vector table for single-cycle ops, hand sequences for repeats/reset/skid.
module tb_bcdu_seq_controller;

  localparam logic [3:0] OP_SHL = 4'd0, OP_SHR = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3, OP_CMP = 4'd4;
  localparam logic [3:0] OP_CLR = 4'd5, OP_MOV = 4'd6, OP_ACA = 4'd7, OP_ACS = 4'd8;
  localparam logic [1:0] ALU_ADD = 2'd0, ALU_SHL = 2'd1, ALU_SHR = 2'd2, ALU_CMP = 2'd3;
  localparam logic [4:0] ZF = 5'd1, CF = 5'd2, GF = 5'd4, EF = 5'd8, TF = 5'd16;

  logic        i_clk, i_rst_n, i_valid, o_ready;
  logic [15:0] i_instr;
  logic [3:0]  i_digit;
  logic        o_wr_en, o_ncp_en, o_add_cin, o_flags_save, o_done, o_illegal;
  logic [1:0]  o_wr_addr, o_rd_addr_a, o_rd_addr_b, o_alu_op_code;
  logic [2:0]  o_shl_amt, o_shr_amt;
  logic [3:0]  o_shl_digit, o_shr_digit;
  logic [4:0]  o_flags_mask;

  bcdu_seq_controller dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_digit(i_digit), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_rd_addr_a(o_rd_addr_a), .o_rd_addr_b(o_rd_addr_b), .o_ncp_en(o_ncp_en),
    .o_alu_op_code(o_alu_op_code), .o_shl_amt(o_shl_amt), .o_shr_amt(o_shr_amt),
    .o_shl_digit(o_shl_digit), .o_shr_digit(o_shr_digit), .o_add_cin(o_add_cin),
    .o_flags_mask(o_flags_mask), .o_flags_save(o_flags_save), .o_done(o_done),
    .o_illegal(o_illegal)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] a0,
                                     input logic [1:0] f, input logic [1:0] a1, input logic [3:0] lo);
    return {op, 2'b00, a0, f, a1, lo};
  endfunction

  // {wr, waddr, rda, rdb, ncp, alu, shl_amt, shr_amt, shl_dig, shr_dig, cin, mask, save, done, ill}
  function automatic logic [32:0] pk(input logic wr, input logic [1:0] wa, input logic [1:0] ra,
                                     input logic [1:0] rb, input logic ncp, input logic [1:0] alu,
                                     input logic [2:0] sla, input logic [2:0] sra, input logic [3:0] sld,
                                     input logic [3:0] srd, input logic cin, input logic [4:0] mask,
                                     input logic save, input logic done, input logic ill);
    return {wr, wa, ra, rb, ncp, alu, sla, sra, sld, srd, cin, mask, save, done, ill};
  endfunction

  function automatic logic [32:0] act_vec();
    return {o_wr_en, o_wr_addr, o_rd_addr_a, o_rd_addr_b, o_ncp_en, o_alu_op_code, o_shl_amt,
            o_shr_amt, o_shl_digit, o_shr_digit, o_add_cin, o_flags_mask, o_flags_save, o_done, o_illegal};
  endfunction

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic [3:0]  digit;
    logic [32:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string name, input logic [15:0] instr, input logic [3:0] digit,
                     input logic [32:0] exp);
    vec_t v;
    v.name = name; v.instr = instr; v.digit = digit; v.exp = exp;
    vq.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [32:0] e;
    logic [9:0]  wr_v, save_v, rdy_v, done_v;
    logic [7:0]  wr8, done8, cmp8;
    int          rd_bad, wr_cnt, acc_edge, exp_edge;
    logic        acc;

    i_rst_n = 1'b0; i_valid = 1'b0; i_instr = '0; i_digit = '0;
    #12;
    check("reset_ctrl", 64'(act_vec()), 64'(pk(0,0,0,0,0,ALU_CMP,0,0,0,0,0,0,0,0,0)));
    check("reset_ready", 64'(o_ready), 64'(1'b1));
    @(posedge i_clk); #1 i_rst_n = 1'b1;

    add("add",     mk(OP_ADD,2,0,0,1),      0, pk(1,2,0,1,0,ALU_ADD,0,0,0,0,0,ZF|CF,0,1,0));
    add("sub",     mk(OP_SUB,3,0,2,1),      0, pk(1,3,2,1,1,ALU_ADD,0,0,0,0,1,ZF|CF,0,1,0));
    add("cmp",     mk(OP_CMP,1,0,2,0),      0, pk(0,1,1,2,0,ALU_CMP,0,0,0,0,0,GF|EF,0,1,0));
    add("clr",     mk(OP_CLR,2,0,0,0),      0, pk(1,2,2,0,0,ALU_CMP,0,0,0,0,0,0,0,1,0));
    add("mov",     mk(OP_MOV,1,0,3,0),      0, pk(1,1,3,3,0,ALU_SHL,0,0,0,0,0,0,0,1,0));
    add("shl_sat", mk(OP_SHL,2,2'b10,0,6),  0, pk(1,2,2,0,0,ALU_SHL,4,0,0,0,0,ZF|TF,0,1,0));
    add("shl_max", mk(OP_SHL,1,2'b10,0,4),  0, pk(1,1,1,0,0,ALU_SHL,4,0,0,0,0,ZF|TF,0,1,0));
    add("shl_z",   mk(OP_SHL,1,2'b10,0,8),  0, pk(1,1,1,0,0,ALU_SHL,0,4,0,0,0,ZF|TF,0,1,0));
    add("shl_key", mk(OP_SHL,1,2'b11,0,10), 3, pk(1,1,1,0,0,ALU_SHL,1,3,3,0,0,ZF|TF,0,1,0));
    add("shl_dig", mk(OP_SHL,0,2'b11,0,4),  9, pk(1,0,0,0,0,ALU_SHL,1,3,4,0,0,ZF|TF,0,1,0));
    add("shr_nw",  mk(OP_SHR,3,2'b00,0,2),  0, pk(0,3,3,0,0,ALU_SHR,2,2,0,0,0,ZF|TF,0,1,0));
    add("shr_dig", mk(OP_SHR,0,2'b11,0,5),  0, pk(1,0,0,0,0,ALU_SHR,3,1,0,5,0,ZF|TF,0,1,0));
    add("aca_n0",  mk(OP_ACA,2,0,3,15),    12, pk(0,2,2,3,0,ALU_ADD,0,0,0,0,0,0,0,1,0));
    add("aca_n1",  mk(OP_ACA,1,0,2,1),      0, pk(1,1,1,2,0,ALU_ADD,0,0,0,0,0,ZF|CF,0,1,0));
    add("acs_n1",  mk(OP_ACS,3,0,1,12),     1, pk(1,3,3,1,1,ALU_ADD,0,0,0,0,1,ZF|CF,0,1,0));
    add("ill_b",   mk(4'hB,1,0,2,0),        0, pk(0,1,1,2,0,ALU_CMP,0,0,0,0,0,0,0,1,1));
    add("ill_f",   mk(4'hF,3,0,0,7),        0, pk(0,3,3,0,0,ALU_CMP,0,0,0,0,0,0,0,1,1));

    foreach (vq[i]) begin
      i_instr = vq[i].instr; i_digit = vq[i].digit; i_valid = 1'b1;
      #1;
      e = vq[i].exp;
      check({vq[i].name, "_rd_c"}, 64'({o_rd_addr_a, o_rd_addr_b}), 64'(e[29:26]));
      @(posedge i_clk); #1 i_valid = 1'b0;
      check(vq[i].name, 64'(act_vec()), 64'(e));
    end

    // Back-to-back single-cycle issue
    i_instr = mk(OP_ADD,1,0,0,1); i_valid = 1'b1;
    @(posedge i_clk); #1 check("b2b_add", 64'({o_done, o_wr_en, o_wr_addr}), 64'({1'b1, 1'b1, 2'd1}));
    i_instr = mk(OP_SUB,2,0,0,1);
    @(posedge i_clk); #1 check("b2b_sub", 64'({o_done, o_wr_en, o_wr_addr}), 64'({1'b1, 1'b1, 2'd2}));
    i_instr = mk(OP_CMP,3,0,0,0);
    @(posedge i_clk); #1 check("b2b_cmp", 64'({o_done, o_wr_en, o_wr_addr}), 64'({1'b1, 1'b0, 2'd3}));
    i_valid = 1'b0;
    @(posedge i_clk); #1;

    // ACA with N taken from the keypad digit (7)
    i_instr = mk(OP_ACA,1,0,2,0); i_digit = 4'd7; i_valid = 1'b1;
    @(posedge i_clk); #1 i_valid = 1'b0; i_instr = mk(OP_CMP,3,0,3,0); i_digit = 4'd0;
    wr_v = '0; save_v = '0; rdy_v = '0; done_v = '0; rd_bad = 0;
    for (int c = 1; c <= 9; c++) begin
      wr_v[c] = o_wr_en; save_v[c] = o_flags_save; rdy_v[c] = o_ready; done_v[c] = o_done;
      if (o_rd_addr_a != 2'd1 || o_rd_addr_b != 2'd2) rd_bad++;
      @(posedge i_clk); #1;
    end
    check("aca7_wr",    64'(wr_v),   64'(10'h0FE));
    check("aca7_save",  64'(save_v), 64'(10'h0FC));
    check("aca7_ready", 64'(rdy_v),  64'(10'h380));
    check("aca7_done",  64'(done_v), 64'(10'h080));
    check("aca7_rd_hold", 64'(rd_bad), 64'(0));

    // Reset in the middle of ACA N=5
    i_instr = mk(OP_ACA,1,0,2,5); i_valid = 1'b1;
    @(posedge i_clk); #1 i_valid = 1'b0;
    @(posedge i_clk); #1;
    check("rst_pre_wr", 64'(o_wr_en), 64'(1'b1));
    i_rst_n = 1'b0;
    #1 check("rst_abort", 64'({o_wr_en, o_ready, o_alu_op_code, o_done, o_flags_save}),
                          64'({1'b0, 1'b1, ALU_CMP, 1'b0, 1'b0}));
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    wr_cnt = 0;
    repeat (6) begin
      @(posedge i_clk); #1 wr_cnt += int'(o_wr_en);
    end
    check("rst_no_wr", 64'(wr_cnt), 64'(0));

    // ACS N=4 followed one cycle later by CMP
    i_instr = mk(OP_ACS,2,0,1,4); i_digit = 4'd0; i_valid = 1'b1;
    @(posedge i_clk); #1 i_instr = mk(OP_CMP,1,0,2,0);
    wr8 = '0; done8 = '0; cmp8 = '0; acc_edge = -1;
    for (int c = 1; c <= 7; c++) begin
      wr8[c] = o_wr_en; done8[c] = o_done; cmp8[c] = o_done && (o_flags_mask == (GF | EF));
      acc = i_valid && o_ready;
      @(posedge i_clk); #1;
      if (acc) begin
        i_valid = 1'b0;
        if (acc_edge < 0) acc_edge = c;
      end
    end
`ifdef BCDU_CTRL_SKID_EN
    exp_edge = 1;
`else
    exp_edge = 4;
`endif
    check("acs4_wr",     64'(wr8),   64'(8'h1E));
    check("acs4_done",   64'(done8), 64'(8'h30));
    check("acs4_cmp",    64'(cmp8),  64'(8'h20));
    check("acs4_accept", 64'(acc_edge), 64'(exp_edge));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
